// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the program loader and the core's decode stage:
// opcodes, functs, loader mnemonic codes, error codes and loader FSM encoding.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_J     = 6'h02;

  // AND is 6'h23 in this core, not the textbook 6'h24
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h23;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [3:0] MN_ADD     = 4'd0;
  localparam logic [3:0] MN_SUB     = 4'd1;
  localparam logic [3:0] MN_AND     = 4'd2;
  localparam logic [3:0] MN_OR      = 4'd3;
  localparam logic [3:0] MN_NOR     = 4'd4;
  localparam logic [3:0] MN_SLT     = 4'd5;
  localparam logic [3:0] MN_JR      = 4'd6;
  localparam logic [3:0] MN_ADDI    = 4'd7;
  localparam logic [3:0] MN_SLTI    = 4'd8;
  localparam logic [3:0] MN_LW      = 4'd9;
  localparam logic [3:0] MN_SW      = 4'd10;
  localparam logic [3:0] MN_BEQ     = 4'd11;
  localparam logic [3:0] MN_JAL     = 4'd12;
  localparam logic [3:0] MN_J       = 4'd13;
  localparam logic [3:0] MN_END     = 4'd14;
  localparam logic [3:0] MN_ILLEGAL = 4'd15;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  function automatic logic [31:0] r_word(input logic [5:0] funct, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

endpackage

// File: rtl/prog_encoder_if.sv
// Symbolic-instruction stream and instruction-memory write port of the program loader.
interface prog_encoder_if #(
  parameter int DWIDTH = 32,
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DWIDTH-1:0] imem_wdata;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: mnemonic plus fields to a 32-bit machine word.
// Fields a mnemonic does not use are forced to zero.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal,
  output logic        is_end
);

  always_comb begin
    word   = '0;
    legal  = 1'b1;
    is_end = 1'b0;
    case (mnem)
      MN_ADD:  word = r_word(FN_ADD, rs, rt, rd);
      MN_SUB:  word = r_word(FN_SUB, rs, rt, rd);
      MN_AND:  word = r_word(FN_AND, rs, rt, rd);
      MN_OR:   word = r_word(FN_OR,  rs, rt, rd);
      MN_NOR:  word = r_word(FN_NOR, rs, rt, rd);
      MN_SLT:  word = r_word(FN_SLT, rs, rt, rd);
      MN_JR:   word = r_word(FN_JR,  rs, 5'd0, 5'd0);
      MN_ADDI: word = {OP_ADDI, rs, rt, imm};
      MN_SLTI: word = {OP_SLTI, rs, rt, imm};
      MN_LW:   word = {OP_LW,   rs, rt, imm};
      MN_SW:   word = {OP_SW,   rs, rt, imm};
      MN_BEQ:  word = {OP_BEQ,  rs, rt, imm};
      MN_JAL:  word = {OP_JAL, target};
      MN_J:    word = {OP_J,   target};
      MN_END:  is_end = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/prog_encoder.sv
// Program loader: accepts symbolic instructions, encodes them and writes them
// sequentially into instruction memory from a base word address.
module prog_encoder
  import mips_isa_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  prog_encoder_if.slave     bus,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              last_slot;
  logic [31:0]       pack_word;
  logic              pack_legal;
  logic              pack_end;

  instr_pack u_pack (
    .mnem   (bus.in_mnem),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .imm    (bus.in_imm),
    .target (bus.in_target),
    .word   (pack_word),
    .legal  (pack_legal),
    .is_end (pack_end)
  );

  assign bus.in_ready = (state == ST_RUN);
  // Gated by rst so a reset landing on the WRITE cycle suppresses the strobe
  assign bus.imem_we  = (state == ST_WRITE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      count          <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      err_code       <= ERR_NONE;
      last_slot      <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state     <= ST_RUN;
            ptr       <= base_addr;
            count     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            last_slot <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.in_valid) begin
            if (!pack_legal) begin
              state    <= ST_ERR;
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
            end else if (pack_end) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (last_slot) begin
              state    <= ST_ERR;
              err      <= 1'b1;
              err_code <= ERR_OVERFLOW;
            end else begin
              state          <= ST_WRITE;
              bus.imem_addr  <= ptr;
              bus.imem_wdata <= DWIDTH'(pack_word);
            end
          end
        end
        ST_WRITE: begin
          ptr       <= ptr + ADDR_W'(1);
          count     <= count + (ADDR_W+1)'(1);
          last_slot <= (ptr == '1);
          state     <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder: an ADDR_W=8 instance for encodings and
// session control, plus an ADDR_W=2 instance for address overflow.
module tb_prog_encoder;
  import mips_isa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1;
  logic [7:0] base0;
  logic [1:0] base1;
  logic [8:0] count0;
  logic [2:0] count1;
  logic       done0, err0, done1, err1;
  logic [1:0] ec0, ec1;

  prog_encoder_if #(.DWIDTH(32), .ADDR_W(8)) b0();
  prog_encoder_if #(.DWIDTH(32), .ADDR_W(2)) b1();

  prog_encoder #(.DWIDTH(32), .ADDR_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .bus(b0.slave),
    .count(count0), .done(done0), .err(err0), .err_code(ec0)
  );

  prog_encoder #(.DWIDTH(32), .ADDR_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .bus(b1.slave),
    .count(count1), .done(done1), .err(err1), .err_code(ec1)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel != 0) ? b1.in_ready : b0.in_ready;
  endfunction
  function automatic logic we(input int sel);
    return (sel != 0) ? b1.imem_we : b0.imem_we;
  endfunction
  function automatic logic [31:0] waddr(input int sel);
    return (sel != 0) ? 32'(b1.imem_addr) : 32'(b0.imem_addr);
  endfunction
  function automatic logic [31:0] wdata(input int sel);
    return (sel != 0) ? b1.imem_wdata : b0.imem_wdata;
  endfunction

  task automatic present(input int sel, input logic [3:0] m, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic [25:0] tgt);
    b0.in_mnem = m;  b0.in_rs = rs; b0.in_rt = rt; b0.in_rd = rd;
    b0.in_imm = imm; b0.in_target = tgt;
    b1.in_mnem = m;  b1.in_rs = rs; b1.in_rt = rt; b1.in_rd = rd;
    b1.in_imm = imm; b1.in_target = tgt;
    if (sel != 0) b1.in_valid = 1'b1;
    else          b0.in_valid = 1'b1;
  endtask

  task automatic drop_valid();
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
  endtask

  task automatic wait_ready(input int sel, input string tag);
    int n = 0;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_ready_timeout"}, 32'(rdy(sel)), 32'd1);
  endtask

  task automatic begin_session(input int sel, input logic [7:0] b);
    base0 = b;
    base1 = b[1:0];
    if (sel != 0) start1 = 1'b1;
    else          start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic write_step(input int sel, input string tag, input logic [3:0] m,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [15:0] imm, input logic [25:0] tgt,
                            input logic [31:0] exp_addr, input logic [31:0] exp_word);
    present(sel, m, rs, rt, rd, imm, tgt);
    wait_ready(sel, tag);
    @(negedge clk);
    drop_valid();
    check({tag, "_we"},   32'(we(sel)),  32'd1);
    check({tag, "_addr"}, waddr(sel),    exp_addr);
    check({tag, "_data"}, wdata(sel),    exp_word);
    check({tag, "_rdy"},  32'(rdy(sel)), 32'd0);
    @(negedge clk);
    check({tag, "_we_off"}, 32'(we(sel)), 32'd0);
  endtask

  task automatic close_step(input int sel, input string tag, input logic [3:0] m);
    present(sel, m, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    wait_ready(sel, tag);
    @(negedge clk);
    drop_valid();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; base0 = '0; base1 = '0;
    drop_valid();
    present(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    drop_valid();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(b0.in_ready), 32'd0);
    check("rst_we",    32'(b0.imem_we),  32'd0);
    check("rst_addr",  32'(b0.imem_addr), 32'd0);
    check("rst_data",  b0.imem_wdata,    32'd0);
    check("rst_count", 32'(count0),      32'd0);
    check("rst_done",  32'(done0),       32'd0);
    check("rst_err",   32'(err0),        32'd0);
    check("rst_ec",    32'(ec0),         32'd0);

    // in_valid in IDLE is ignored
    present(0, MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    repeat (2) @(negedge clk);
    check("idle_ignore_we", 32'(b0.imem_we), 32'd0);
    drop_valid();

    // Single ADD then END
    begin_session(0, 8'h00);
    check("s1_ready", 32'(b0.in_ready), 32'd1);
    write_step(0, "add", MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h0, 32'h00221820);
    close_step(0, "end1", MN_END);
    check("end1_done",  32'(done0),  32'd1);
    check("end1_count", 32'(count0), 32'd1);
    check("end1_ready", 32'(b0.in_ready), 32'd0);
    check("end1_we",    32'(b0.imem_we),  32'd0);

    // Back-to-back stream from base 5 with in_valid held high
    begin_session(0, 8'h05);
    check("s2_done_clr",  32'(done0),  32'd0);
    check("s2_count_clr", 32'(count0), 32'd0);
    present(0, MN_ADDI, 5'd0, 5'd1, 5'd0, 16'hFFFF, 26'd0);
    @(negedge clk);
    check("addi_we",   32'(b0.imem_we), 32'd1);
    check("addi_addr", 32'(b0.imem_addr), 32'd5);
    check("addi_data", b0.imem_wdata, 32'h2001FFFF);
    check("addi_rdy",  32'(b0.in_ready), 32'd0);
    present(0, MN_LW, 5'd1, 5'd2, 5'd0, 16'h0004, 26'd0);
    @(negedge clk);
    check("gap1_rdy", 32'(b0.in_ready), 32'd1);
    check("gap1_we",  32'(b0.imem_we),  32'd0);
    @(negedge clk);
    check("lw_we",   32'(b0.imem_we), 32'd1);
    check("lw_addr", 32'(b0.imem_addr), 32'd6);
    check("lw_data", b0.imem_wdata, 32'h8C220004);
    check("lw_rdy",  32'(b0.in_ready), 32'd0);
    present(0, MN_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'd0);
    @(negedge clk);
    check("gap2_rdy", 32'(b0.in_ready), 32'd1);
    @(negedge clk);
    check("beq_we",   32'(b0.imem_we), 32'd1);
    check("beq_addr", 32'(b0.imem_addr), 32'd7);
    check("beq_data", b0.imem_wdata, 32'h1022FFFE);
    drop_valid();
    @(negedge clk);
    check("beq_hold_addr", 32'(b0.imem_addr), 32'd7);
    close_step(0, "end2", MN_END);
    check("end2_count", 32'(count0), 32'd3);

    // Field masking and remaining formats
    begin_session(0, 8'h20);
    write_step(0, "and", MN_AND, 5'd5, 5'd6, 5'd4, 16'hFFFF, 26'h3FFFFFF, 32'h20, 32'h00A62023);
    write_step(0, "jr",  MN_JR,  5'd31, 5'd7, 5'd9, 16'h1234, 26'h3FFFFFF, 32'h21, 32'h03E00008);
    write_step(0, "jal", MN_JAL, 5'd3, 5'd4, 5'd5, 16'hABCD, 26'h0000010, 32'h22, 32'h0C000010);
    write_step(0, "j",   MN_J,   5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0123456, 32'h23, 32'h08123456);
    close_step(0, "end3", MN_END);
    check("end3_count", 32'(count0), 32'd4);

    // Illegal mnemonic after one write
    begin_session(0, 8'h40);
    write_step(0, "add2", MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h40, 32'h00221820);
    close_step(0, "ill", MN_ILLEGAL);
    check("ill_err",   32'(err0),  32'd1);
    check("ill_ec",    32'(ec0),   32'd1);
    check("ill_done",  32'(done0), 32'd0);
    check("ill_count", 32'(count0), 32'd1);
    check("ill_we",    32'(b0.imem_we), 32'd0);
    present(0, MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    repeat (2) @(negedge clk);
    check("err_ignore_we",  32'(b0.imem_we), 32'd0);
    check("err_ignore_cnt", 32'(count0), 32'd1);
    drop_valid();
    begin_session(0, 8'h50);
    check("s5_err_clr", 32'(err0), 32'd0);
    check("s5_ec_clr",  32'(ec0),  32'd0);
    check("s5_cnt_clr", 32'(count0), 32'd0);
    write_step(0, "sub", MN_SUB, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 32'h50, 32'h00E84822);
    close_step(0, "end5", MN_END);

    // Address overflow on the 4-word instance
    begin_session(1, 8'h02);
    write_step(1, "or",   MN_OR,   5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'd2, 32'h00221825);
    write_step(1, "slti", MN_SLTI, 5'd1, 5'd2, 5'd0, 16'h0007, 26'd0, 32'd3, 32'h28220007);
    close_step(1, "ovf", MN_SW);
    check("ovf_err",   32'(err1),  32'd1);
    check("ovf_ec",    32'(ec1),   32'd2);
    check("ovf_we",    32'(b1.imem_we), 32'd0);
    check("ovf_count", 32'(count1), 32'd2);
    @(negedge clk);
    check("ovf_we2",   32'(b1.imem_we), 32'd0);
    check("ovf_addr",  32'(b1.imem_addr), 32'd3);

    // Reset landing on the WRITE cycle
    begin_session(0, 8'h60);
    present(0, MN_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    wait_ready(0, "rstw");
    @(negedge clk);
    drop_valid();
    rst = 1'b1;
    #1;
    check("rstw_we", 32'(b0.imem_we), 32'd0);
    @(negedge clk);
    check("rstw_ready", 32'(b0.in_ready), 32'd0);
    check("rstw_we2",   32'(b0.imem_we),  32'd0);
    check("rstw_addr",  32'(b0.imem_addr), 32'd0);
    check("rstw_data",  b0.imem_wdata,    32'd0);
    check("rstw_count", 32'(count0), 32'd0);
    check("rstw_done",  32'(done0),  32'd0);
    check("rstw_err",   32'(err0),   32'd0);
    check("rstw_ec",    32'(ec0),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    begin_session(0, 8'h70);
    write_step(0, "addi2", MN_ADDI, 5'd0, 5'd3, 5'd0, 16'h1234, 26'd0, 32'h70, 32'h20031234);
    check("addi2_count", 32'(count0), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/prog_encoder.md
# prog_encoder

Instruction encoder and program loader for the single-cycle MIPS core. It accepts symbolic instructions (mnemonic plus fields) over a valid/ready stream and packs each into a 32-bit machine word. Each word is written sequentially into instruction memory, starting at a base word address. Benches and the boot path use it to build programs. Its encodings are the exact inverse of the core's decode stage, so any word it emits decodes back to the same mnemonic and fields.

## Interface
Parameters:
- DWIDTH, 32, instruction/data word width
- ADDR_W, 8, instruction-memory word-address width (depth 2^ADDR_W)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a load session (honoured only in IDLE, DONE, ERR)
- base_addr  in  ADDR_W  first word address of the session
- in_valid  in  1  symbolic instruction present
- in_ready  out  1  encoder can accept
- in_mnem  in  4  mnemonic code (see Operation)
- in_rs / in_rt / in_rd  in  5 each  register IDs
- in_imm  in  16  immediate / branch offset, raw
- in_target  in  26  jump target field
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of write
- imem_wdata  out  DWIDTH  encoded word
- count  out  ADDR_W+1  words written this session
- done  out  1  session ended by END
- err  out  1  session aborted
- err_code  out  2  01 illegal mnemonic, 10 address overflow

## Operation
- Mnemonic codes and encodings, all in field order {op, rs, rt, rd, shamt=0, funct}:
  - R-type, op 6'h00: ADD=0 funct 20, SUB=1 funct 22, AND=2 funct 23, OR=3 funct 25, NOR=4 funct 27, SLT=5 funct 2a.
  - AND uses funct 6'h23 (core convention, not the standard 6'h24).
  - JR=6: {6'h00, rs, 15'b0, 6'h08}.
- I-type, {op, rs, rt, imm}: ADDI=7 op 08, SLTI=8 op 0a, LW=9 op 23, SW=10 op 2b, BEQ=11 op 04. Immediate passed raw; no sign handling.
- J-type, {op, target}: JAL=12 op 03, J=13 op 02.
- END=14 closes the session; no write. Code 15 is illegal.
- Unused fields for a mnemonic are ignored and forced to zero in the word.
- FSM states:
  - IDLE: in_ready=0. start -> RUN; load ptr<=base_addr, count<=0, clear done/err/err_code, clear last-slot flag.
  - RUN: in_ready=1. On handshake:
    - legal non-END, no overflow -> WRITE; latch word into imem_wdata, imem_addr<=ptr.
    - END -> DONE.
    - code 15 -> ERR, err_code=01.
    - last-slot flag set -> ERR, err_code=10, no write.
  - WRITE: imem_we=1 for exactly one cycle. Next: ptr<=ptr+1 (wraps mod 2^ADDR_W), count<=count+1, last-slot flag<=(ptr==2^ADDR_W-1). Return to RUN.
  - DONE / ERR: in_ready=0, done or err held high; start -> RUN as from IDLE.
- start in RUN or WRITE is ignored. in_valid outside RUN is ignored, with no side effects.

## Timing
- Reset value of all outputs is 0: in_ready, imem_we, imem_addr, imem_wdata, count, done, err, err_code. State returns to IDLE.
- Reset mid-session, including in WRITE: no further write strobe issues. The partial program is left in memory.
- Handshake accepted in cycle N → imem_we high in cycle N+1, with addr/wdata stable that cycle → in_ready high again in N+2. Peak throughput is 1 word per 2 cycles.
- in_ready does not depend combinationally on in_valid. Producer holds fields while in_valid && !in_ready.
- END or illegal accepted in cycle N → done/err high from N+1. count then reflects all completed writes.
- imem_addr and imem_wdata hold their last value outside WRITE. Only imem_we qualifies them.

## Structure
- Shared package `mips_isa_pkg`:
  - opcode and funct localparams, shared with the decode stage
  - mnemonic codes 0–15
  - err_code values
  - FSM state encoding
- Sub-module `instr_pack` (combinational): mnemonic and fields → {word, legal, is_end}. The FSM wrapper owns pointer, counters, and the handshake.

## Test plan
- ADD rs=1 rt=2 rd=3, base 0 → single write addr 0, data 0x00221820. Then END → done=1, count=1.
- Stream back-to-back, in_valid held high:
  - ADDI rt=1 imm=FFFF → 0x2001FFFF
  - LW rs=1 rt=2 imm=4 → 0x8C220004
  - BEQ rs=1 rt=2 imm=FFFE → 0x1022FFFE
  - Expect addrs 5,6,7 from base 5 and in_ready low every other cycle.
- AND rs=5 rt=6 rd=4 → 0x00A62023; JR rs=31 → 0x03E00008; JAL target 0x10 → 0x0C000010. Also J with garbage rs/rt → only target bits set.
- Mnemonic 15 after one write → err=1, err_code=01, no extra strobe, count=1. Then start → clean new session.
- ADDR_W=2, base 2: three legal instructions → writes at 2, 3. Third → err_code=10 with no write. Address 0 is never written.
- rst asserted in the WRITE cycle and then start: no strobe in the rst cycle, all outputs 0 next cycle. Session restarts at the new base.
